// File: rtl/eth_avalon_txbd_fetch_pkg.sv
// rtl/eth_avalon_txbd_fetch_pkg.sv - TX BD bit positions, FSM encoding and sizing helper
package eth_avalon_txbd_fetch_pkg;

    localparam int BD_RD  = 15;
    localparam int BD_IRQ = 14;
    localparam int BD_WR  = 13;
    localparam int BD_PAD = 12;
    localparam int BD_CRC = 11;
    localparam int BD_STAT_W = 9;

    // Status field {UR, RTRY[3:0], RL, LC, DF, CS}
    localparam int ST_UR = 8;
    localparam int ST_RL = 3;
    localparam int ST_LC = 2;
    localparam int ST_CS = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD0,
        S_CHK,
        S_RD1,
        S_LAT,
        S_OFFER,
        S_WSTAT,
        S_WB,
        S_ADV
    } txbd_state_t;

    // Bits needed to hold 'value'; never less than one.
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) begin
                bits = i + 1;
            end
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/eth_avalon_txbd_fetch.sv
// rtl/eth_avalon_txbd_fetch.sv - TX BD poll, offer to DMA and status writeback on BD RAM port B
module eth_avalon_txbd_fetch
    import eth_avalon_txbd_fetch_pkg::*;
#(
    parameter int  DEPTH         = 128,
    parameter int  POLL_INTERVAL = 16,
    localparam int AW            = clogb2(DEPTH - 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           tx_bd_num,
    output logic [AW-1:0]        bd_address,
    output logic                 bd_wren,
    output logic [31:0]          bd_wdata,
    input  logic [31:0]          bd_rdata,
    output logic                 desc_valid,
    input  logic                 desc_ready,
    output logic [15:0]          desc_len,
    output logic [31:0]          desc_ptr,
    output logic [2:0]           desc_ctrl,
    input  logic                 stat_valid,
    output logic                 stat_ready,
    input  logic [BD_STAT_W-1:0] stat_bits,
    output logic [7:0]           cur_index,
    output logic                 txb_irq,
    output logic                 txe_irq
);

    localparam int PW = clogb2(POLL_INTERVAL);

    txbd_state_t          r_state;
    txbd_state_t          w_next;
    logic [15:0]          r_len;
    logic [14:9]          r_flags;
    logic [31:0]          r_ptr;
    logic [BD_STAT_W-1:0] r_stat;
    logic [7:0]           r_cur_index;
    logic [PW-1:0]        r_poll;
    logic [AW-1:0]        r_bd_address;

    logic          w_can_start;
    logic          w_bd_ready;
    logic          w_wrap;
    logic          w_err;
    logic [AW-1:0] w_addr_w0;
    logic [AW-1:0] w_addr_w1;

    assign w_can_start = enable && (tx_bd_num != 8'd0) && (r_poll == '0);
    assign w_bd_ready  = bd_rdata[BD_RD] && enable;
    assign w_addr_w0   = AW'({r_cur_index, 1'b0});
    assign w_addr_w1   = AW'({r_cur_index, 1'b1});
    // A stale index beyond a shrunk ring also wraps here.
    assign w_wrap      = r_flags[BD_WR] || (({1'b0, r_cur_index} + 9'd1) >= {1'b0, tx_bd_num});
    assign w_err       = r_stat[ST_UR] | r_stat[ST_RL] | r_stat[ST_LC] | r_stat[ST_CS];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_can_start) w_next = S_RD0;
            S_RD0:   w_next = S_CHK;
            S_CHK:   w_next = w_bd_ready ? S_RD1 : S_IDLE;
            S_RD1:   w_next = S_LAT;
            S_LAT:   w_next = S_OFFER;
            S_OFFER: if (desc_ready) w_next = S_WSTAT;
            S_WSTAT: if (stat_valid) w_next = S_WB;
            S_WB:    w_next = S_ADV;
            S_ADV:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        desc_valid = (r_state == S_OFFER);
        stat_ready = (r_state == S_WSTAT);
        bd_wren    = 1'b0;
        bd_wdata   = '0;
        txb_irq    = 1'b0;
        txe_irq    = 1'b0;
        if (r_state == S_WB) begin
            bd_wren  = 1'b1;
            bd_wdata = {r_len, 1'b0, r_flags, r_stat};
            txb_irq  = r_flags[BD_IRQ] & ~w_err;
            txe_irq  = r_flags[BD_IRQ] & w_err;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_len        <= '0;
            r_flags      <= '0;
            r_ptr        <= '0;
            r_stat       <= '0;
            r_cur_index  <= '0;
            r_poll       <= '0;
            r_bd_address <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_can_start) begin
                        r_bd_address <= w_addr_w0;
                    end else if (r_poll != '0) begin
                        r_poll <= r_poll - 1'b1;
                    end
                end
                S_CHK: begin
                    r_len   <= bd_rdata[31:16];
                    r_flags <= bd_rdata[14:9];
                    if (w_bd_ready) begin
                        r_bd_address <= w_addr_w1;
                    end else begin
                        r_poll <= PW'(POLL_INTERVAL - 1);
                    end
                end
                S_LAT: r_ptr <= bd_rdata;
                S_WSTAT: begin
                    if (stat_valid) begin
                        r_stat       <= stat_bits;
                        r_bd_address <= w_addr_w0;
                    end
                end
                S_ADV: begin
                    r_cur_index <= w_wrap ? 8'd0 : r_cur_index + 8'd1;
                    r_poll      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bd_address = r_bd_address;
    assign desc_len   = r_len;
    assign desc_ptr   = r_ptr;
    assign desc_ctrl  = {r_flags[BD_IRQ], r_flags[BD_PAD], r_flags[BD_CRC]};
    assign cur_index  = r_cur_index;

endmodule

// File: tb/tb_eth_avalon_txbd_fetch.sv
// tb/tb_eth_avalon_txbd_fetch.sv - scoreboard bench for the TX BD fetch engine
module tb_eth_avalon_txbd_fetch;

    localparam int AW = 7;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  tx_bd_num = 8'd4;
    logic [AW-1:0] bd_address;
    logic        bd_wren;
    logic [31:0] bd_wdata;
    logic [31:0] bd_rdata = 32'h0;
    logic        desc_valid;
    logic        desc_ready = 1'b0;
    logic [15:0] desc_len;
    logic [31:0] desc_ptr;
    logic [2:0]  desc_ctrl;
    logic        stat_valid = 1'b0;
    logic        stat_ready;
    logic [8:0]  stat_bits = 9'h0;
    logic [7:0]  cur_index;
    logic        txb_irq;
    logic        txe_irq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    eth_avalon_txbd_fetch dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .tx_bd_num  (tx_bd_num),
        .bd_address (bd_address),
        .bd_wren    (bd_wren),
        .bd_wdata   (bd_wdata),
        .bd_rdata   (bd_rdata),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_len   (desc_len),
        .desc_ptr   (desc_ptr),
        .desc_ctrl  (desc_ctrl),
        .stat_valid (stat_valid),
        .stat_ready (stat_ready),
        .stat_bits  (stat_bits),
        .cur_index  (cur_index),
        .txb_irq    (txb_irq),
        .txe_irq    (txe_irq)
    );

    // Dual-port BD RAM: port A is the host, port B the DUT.
    logic [31:0] ram [0:127] = '{default: 32'h0};
    logic        host_we = 1'b0;
    logic [6:0]  host_addr = 7'h0;
    logic [31:0] host_data = 32'h0;

    always @(posedge clock) begin
        if (host_we) ram[host_addr] <= host_data;
        if (bd_wren) ram[bd_address] <= bd_wdata;
        bd_rdata <= ram[bd_address];
    end

    typedef struct {
        int          idx;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nxt;
    } bd_t;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  irq;
        int          nxt;
    } wb_t;

    bd_t        offer_q[$];
    wb_t        wb_q[$];
    logic [8:0] stat_q[$];
    bd_t        cur_bd;
    bit         hold_ready = 1'b0;
    bit         block_stat = 1'b0;
    int         wb_count = 0;
    int         m_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // DMA model: random ready/valid, status chosen from stat_q or at random.
    initial begin
        wb_t w;
        logic err;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                desc_ready = 1'b0;
                stat_valid = 1'b0;
            end else begin
                desc_ready = desc_valid && !hold_ready && ($urandom_range(0, 3) != 0);
                if (!stat_ready || block_stat) begin
                    stat_valid = 1'b0;
                end else if (!stat_valid && $urandom_range(0, 2) == 0) begin
                    if (stat_q.size() != 0) stat_bits = stat_q.pop_front();
                    else if ($urandom_range(0, 1) == 0) stat_bits = 9'h0;
                    else stat_bits = 9'($urandom);
                    stat_valid = 1'b1;
                    err    = stat_bits[8] | stat_bits[3] | stat_bits[2] | stat_bits[0];
                    w.addr = 7'(2 * cur_bd.idx);
                    w.data = (cur_bd.w0 & 32'hFFFF_7E00) | {23'h0, stat_bits};
                    w.irq  = {cur_bd.w0[14] & ~err, cur_bd.w0[14] & err};
                    w.nxt  = cur_bd.nxt;
                    wb_q.push_back(w);
                end
            end
        end
    end

    // Monitor: offers, writebacks, irq pulses and ring index.
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic        p_shs = 1'b0;
    logic [15:0] p_len = 16'h0;
    logic [31:0] p_ptr = 32'h0;
    logic [2:0]  p_ctrl = 3'h0;
    int          idx_wait = 0;
    int          idx_exp = 0;

    always @(negedge clock) begin : monitor
        bd_t b;
        wb_t w;
        if (reset) begin
            p_valid  = 1'b0;
            p_shs    = 1'b0;
            idx_wait = 0;
        end else begin
            if (desc_valid && p_valid && !p_ready) begin
                check("offer_stable_len_ctrl", 32'({desc_len, desc_ctrl}), 32'({p_len, p_ctrl}));
                check("offer_stable_ptr", desc_ptr, p_ptr);
            end
            if (desc_valid && desc_ready) begin
                if (offer_q.size() == 0) begin
                    check("offer_unexpected", 32'd1, 32'd0);
                end else begin
                    b = offer_q.pop_front();
                    check("desc_len", 32'(desc_len), 32'(b.w0[31:16]));
                    check("desc_ptr", desc_ptr, b.w1);
                    check("desc_ctrl", 32'(desc_ctrl), 32'({b.w0[14], b.w0[12], b.w0[11]}));
                    cur_bd = b;
                end
            end
            if (bd_wren) begin
                check("wb_latency", 32'(p_shs), 32'd1);
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    w = wb_q.pop_front();
                    check("wb_addr", 32'(bd_address), 32'(w.addr));
                    check("wb_data", bd_wdata, w.data);
                    check("wb_irq", 32'({txb_irq, txe_irq}), 32'(w.irq));
                    idx_exp  = w.nxt;
                    idx_wait = 3;
                    wb_count++;
                end
            end else if (txb_irq || txe_irq) begin
                check("irq_outside_wb", 32'({txb_irq, txe_irq}), 32'd0);
            end
            if (idx_wait > 0) begin
                idx_wait--;
                if (idx_wait == 0) check("cur_index", 32'(cur_index), 32'(idx_exp));
            end
            p_valid = desc_valid;
            p_ready = desc_ready;
            p_len   = desc_len;
            p_ptr   = desc_ptr;
            p_ctrl  = desc_ctrl;
            p_shs   = stat_valid && stat_ready;
        end
    end

    task automatic host_write(input int addr, input logic [31:0] data);
        @(posedge clock);
        #1;
        host_we   = 1'b1;
        host_addr = 7'(addr);
        host_data = data;
        @(posedge clock);
        #1;
        host_we = 1'b0;
    endtask

    task automatic post_bd(input logic [31:0] w0, input logic [31:0] w1);
        bd_t b;
        b.idx = m_idx;
        b.w0  = w0;
        b.w1  = w1;
        b.nxt = (w0[13] || (m_idx + 1 >= int'(tx_bd_num))) ? 0 : m_idx + 1;
        offer_q.push_back(b);
        host_write(2 * m_idx + 1, w1);
        host_write(2 * m_idx, w0);
        m_idx = b.nxt;
    endtask

    task automatic wait_wb(input int target, input string name);
        int n;
        n = 0;
        while (wb_count < target && n < 400) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(wb_count >= target), 32'd1);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, 32'(|{bd_address, bd_wren, bd_wdata, desc_valid, desc_len, desc_ptr,
                          desc_ctrl, stat_ready, cur_index, txb_irq, txe_irq}), 32'd0);
    endtask

    function automatic logic [31:0] rand_w0();
        return {16'($urandom_range(1, 1518)), 1'b1, 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 2'($urandom), 9'($urandom)};
    endfunction

    initial begin
        int          n;
        int          saved_idx;
        logic [31:0] saved_w0;
        logic [AW-1:0] saved_addr;
        bit          moved;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset_outputs");

        // Ready BD0 from the reference example.
        @(posedge clock);
        #1;
        reset = 1'b0;
        enable = 1'b1;
        tx_bd_num = 8'd4;
        stat_q.push_back(9'h000);
        post_bd(32'h0040_D800, 32'h0000_1000);
        wait_wb(1, "bd0_done");
        check("bd0_ram_word0", ram[0], 32'h0040_5800);

        // Not-ready descriptor is polled but never offered.
        host_write(2 * m_idx, 32'h0040_0000);
        repeat (60) @(negedge clock);
        check("no_offer_while_not_ready", 32'(desc_valid), 32'd0);
        repeat ($urandom_range(0, 17)) @(posedge clock);
        post_bd(32'h0040_C000, 32'h0000_2000);
        n = 0;
        while (!desc_valid && n < 22) begin
            @(negedge clock);
            n++;
        end
        check("poll_latency", 32'(desc_valid), 32'd1);
        wait_wb(2, "bd1_done");

        // Ring wrap at the last BD, then the WR bit.
        post_bd(rand_w0() & ~32'h2000, 32'($urandom));
        post_bd(rand_w0() & ~32'h2000, 32'($urandom));
        wait_wb(4, "wrap_last_done");
        post_bd(rand_w0() & ~32'h2000, 32'($urandom));
        post_bd(32'h0020_A000, 32'($urandom));
        wait_wb(6, "wrap_wr_done");

        // Underrun with and without IRQ.
        stat_q.push_back(9'h100);
        post_bd(32'h0040_C000, 32'h0000_3000);
        wait_wb(7, "ur_irq_done");
        stat_q.push_back(9'h100);
        post_bd(32'h0040_8000, 32'h0000_4000);
        wait_wb(8, "ur_noirq_done");

        // Random frames with a varying ring size.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #1;
                tx_bd_num = 8'($urandom_range(1, 6));
            end
            post_bd(rand_w0(), 32'($urandom));
            wait_wb(9 + i, "random_done");
        end

        // Reset while waiting for status: no writeback, RD survives.
        block_stat = 1'b1;
        saved_idx  = m_idx;
        saved_w0   = rand_w0();
        post_bd(saved_w0, 32'($urandom));
        n = 0;
        while (!stat_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("reach_wstat", 32'(stat_ready), 32'd1);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_outputs_zero("mid_reset_outputs");
        check("mid_reset_bd_kept", ram[2 * saved_idx], saved_w0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        block_stat = 1'b0;
        m_idx = 0;
        host_write(2 * saved_idx, 32'h0);
        repeat (5) @(negedge clock);
        check("post_reset_idle", 32'({desc_valid, stat_ready, cur_index}), 32'd0);

        // Offer held while enable drops; then no further reads.
        @(posedge clock);
        #1;
        enable = 1'b1;
        hold_ready = 1'b1;
        post_bd(rand_w0(), 32'($urandom));
        n = 0;
        while (!desc_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("held_offer_seen", 32'(desc_valid), 32'd1);
        @(posedge clock);
        #1;
        enable = 1'b0;
        repeat (10) @(negedge clock);
        check("offer_held_after_disable", 32'(desc_valid), 32'd1);
        hold_ready = 1'b0;
        wait_wb(wb_count + 1, "disabled_done");
        saved_addr = bd_address;
        moved = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bd_address != saved_addr || desc_valid || bd_wren) moved = 1'b1;
        end
        check("disabled_no_reads", 32'(moved), 32'd0);

        check("offer_q_drained", 32'(offer_q.size()), 32'd0);
        check("wb_q_drained", 32'(wb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_avalon_txbd_fetch.md
Name: eth_avalon_txbd_fetch

Overview:
TX buffer-descriptor engine on the MAC side of the dual-port BD RAM. The host writes TX descriptors through RAM port A; this block reads them through port B. It polls the current descriptor for the READY bit and offers the length, pointer and control bits to the TX DMA. It then writes the TX status back into the same descriptor and clears READY, so the host sees completion.

Parameters:
DEPTH, 128, BD RAM depth in 32-bit words; AW = clogb2(DEPTH-1) from eth_avalon_functions.v
POLL_INTERVAL, 16, idle cycles between re-reads of a not-ready descriptor (min 1)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  TX enable (mode register TXEN)
tx_bd_num  in  8  number of TX BDs; TX BD n occupies words 2n (ctrl/status) and 2n+1 (pointer)
bd_address  out  AW  RAM port B address
bd_wren  out  1  RAM port B write enable
bd_wdata  out  32  RAM port B write data
bd_rdata  in  32  RAM port B q; valid one clock after bd_address is presented
desc_valid  out  1  descriptor offer to TX DMA
desc_ready  in  1  DMA accepts the offer
desc_len  out  16  frame length (word0[31:16])
desc_ptr  out  32  buffer pointer (word1)
desc_ctrl  out  3  {IRQ, PAD, CRC} = word0[14], word0[12], word0[11]
stat_valid  in  1  DMA reports that the frame is done
stat_ready  out  1  status accepted
stat_bits  in  9  {UR, RTRY[3:0], RL, LC, DF, CS}; written to word0[8:0]
cur_index  out  8  current TX BD index
txb_irq  out  1  1-cycle pulse: IRQ bit set, no error
txe_irq  out  1  1-cycle pulse: IRQ bit set, error (UR|RL|LC|CS)

Behaviour:
- Reset values: all outputs 0. cur_index=0. Poll counter=0. FSM in IDLE.
- FSM states: IDLE, RD0, CHK, RD1, LAT, OFFER, WSTAT, WB, ADV.
- IDLE:
  - If enable=1 and tx_bd_num!=0 and the poll counter is 0, drive bd_address=2*cur_index and go to RD0.
  - Otherwise decrement the poll counter (saturating at 0).
- RD0 -> CHK: bd_rdata holds word0 in CHK. Latch word0.
- CHK:
  - If RD (bit15)=0 or enable=0: load the poll counter with POLL_INTERVAL-1 and go to IDLE.
  - Otherwise drive bd_address=2*cur_index+1 and go to RD1.
- RD1 -> LAT: latch word1 into desc_ptr. Go to OFFER.
- OFFER: desc_valid=1, with desc_* held stable until desc_ready is sampled high. Go to WSTAT. The offer is never withdrawn, even if enable drops.
- WSTAT: stat_ready=1. When stat_valid=1, latch stat_bits and go to WB. stat_ready is 1 only in WSTAT.
- WB: one-cycle write.
  - bd_wren=1, bd_address=2*cur_index.
  - bd_wdata = {word0[31:16], 1'b0, word0[14:9], stat_bits}, i.e. RD cleared, other control bits preserved.
  - Pulse txb_irq or txe_irq in this same cycle, gated by word0[14].
- ADV: if WR (bit13)=1 or cur_index>=tx_bd_num-1, cur_index<=0; otherwise cur_index+1. Poll counter=0, then go to IDLE. The next descriptor is therefore checked immediately.
- Port B writes only in WB. Port B address is don't-care outside RD0/RD1/WB, but is held stable.
- If tx_bd_num is reduced below cur_index+1 while idle, the next ADV wraps to 0. A read at the stale index is permitted.
- Latency: IDLE to desc_valid is 4 cycles for a ready BD. stat_valid to bd_wren is 1 cycle.
- Reset mid-operation: abort immediately with no writeback. The descriptor keeps RD=1.

Decomposition:
- Add the BD bit positions (RD, IRQ, WR, PAD, CRC, status field) and the FSM state encodings as localparams in eth_avalon_functions.v / a shared eth_avalon_defines include.
- Single flat module. The poll counter is inline, so no sub-module is needed.

Test Plan:
1. tx_bd_num=4, BD0 w0=0x0040D800, w1=0x00001000, enable=1 -> desc_valid with len=0x0040, ptr=0x1000, ctrl=3'b111; stat_bits=0 -> write 0x00405800 to address 0, one txb_irq pulse, cur_index=1.
2. BD0 w0=0x00400000 (RD=0) -> no desc_valid; reads of address 0 recur every 18 cycles (POLL_INTERVAL + 2); host then sets RD -> offer follows within 18+4 cycles.
3. BD1 with WR bit (w0=0x0020A000) completes -> cur_index=0. Separately, BD3 with tx_bd_num=4 completes -> cur_index=0.
4. stat_bits=0x100 (UR) with IRQ=1 -> written w0[8:0]=0x100, RD=0, txe_irq pulse, no txb_irq. Same with IRQ=0 -> neither irq pulses.
5. Reset asserted in WSTAT -> next cycle all outputs 0, cur_index=0, bd_wren never asserted, BD0 word0 unchanged.
6. enable dropped while desc_valid=1 and desc_ready=0 for 10 cycles -> offer held with stable values; on completion, writeback occurs; the FSM then stays in IDLE with no reads.
